// File: rtl/popcnt_seq_ctrl.sv
// Multi-cycle population counter: one CHUNK-bit counter is reused once per beat
// to build cpop/cpopw results for XLEN-bit operands.
module popcnt_seq_ctrl #(
   parameter int XLEN  = 64,
   parameter int CHUNK = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ReqValid,
   output logic                   ReqReady,
   input  logic                   ReqW,
   input  logic [XLEN-1:0]        ReqOperand,
   input  logic                   Flush,
   output logic                   RspValid,
   input  logic                   RspReady,
   output logic [$clog2(XLEN):0]  RspPopCnt,
   output logic                   Busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a source holds valid and payload stable until it is taken.

   localparam int CW      = $clog2(XLEN) + 1;
   localparam int NB_FULL = XLEN / CHUNK;
   localparam int NB_W    = 32 / CHUNK;
   localparam int BW      = $clog2(NB_FULL + 1);

   localparam logic [BW-1:0]   LAST_FULL = BW'(NB_FULL - 1);
   localparam logic [BW-1:0]   LAST_W    = BW'(NB_W - 1);
   localparam logic [XLEN-1:0] LO_MASK   = XLEN'(64'h0000_0000_FFFF_FFFF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [XLEN-1:0]   sh, sh_shift, load_val;
   logic [CW-1:0]     acc, chunk_cnt;
   logic [BW-1:0]     beat;
   logic              w_q, load_w, accept, last_beat;

   function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < CHUNK; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   // ReqW only has meaning when the operand is wider than a word.
   assign load_w    = ReqW && (XLEN > 32);
   assign load_val  = load_w ? (ReqOperand & LO_MASK) : ReqOperand;
   assign sh_shift  = sh >> CHUNK;
   assign chunk_cnt = popcount(sh[CHUNK-1:0]);
   assign last_beat = (beat == (w_q ? LAST_W : LAST_FULL));

   assign RspPopCnt = acc;
   assign Busy      = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ReqReady = 1'b0;
      RspValid = 1'b0;
      case (state)
         IDLE: begin
            ReqReady = ~Flush;
            if (ReqValid && ReqReady) state_nx = COUNT;
         end
         COUNT: begin
            // Stop early once nothing is left to count.
            if (last_beat || (sh_shift == '0)) state_nx = DONE;
         end
         DONE: begin
            RspValid = 1'b1;
            ReqReady = RspReady & ~Flush;
            if (RspReady) state_nx = ReqValid ? COUNT : IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (Flush) state_nx = IDLE;
      accept = ReqValid && ReqReady;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh   <= '0;
         acc  <= '0;
         beat <= '0;
         w_q  <= 1'b0;
      end else if (Flush) begin
         sh   <= '0;
         acc  <= '0;
         beat <= '0;
         w_q  <= 1'b0;
      end else if (accept) begin
         sh   <= load_val;
         acc  <= '0;
         beat <= '0;
         w_q  <= load_w;
      end else if (state == COUNT) begin
         sh   <= sh_shift;
         acc  <= acc + chunk_cnt;
         beat <= beat + BW'(1);
      end
   end

endmodule

// File: tb/tb_popcnt_seq_ctrl.sv
// Directed bench for popcnt_seq_ctrl (XLEN=64, CHUNK=16); inputs change and
// outputs are sampled on the falling clock edge.
module tb_popcnt_seq_ctrl;

   logic        clk;
   logic        reset_n;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqW;
   logic [63:0] ReqOperand;
   logic        Flush;
   logic        RspValid;
   logic        RspReady;
   logic [6:0]  RspPopCnt;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   popcnt_seq_ctrl #(.XLEN(64), .CHUNK(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqW       (ReqW),
      .ReqOperand (ReqOperand),
      .Flush      (Flush),
      .RspValid   (RspValid),
      .RspReady   (RspReady),
      .RspPopCnt  (RspPopCnt),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge and leave the bench at the falling
   // edge right after the accept edge.
   task automatic start_op(input string tag, input logic [63:0] op, input logic w);
      ReqValid   = 1'b1;
      ReqOperand = op;
      ReqW       = w;
      #1;
      check({tag, "_req_ready"}, 64'(ReqReady), 64'd1);
      @(posedge clk);
      @(negedge clk);
      ReqValid = 1'b0;
      check({tag, "_acc_clear"}, 64'(RspPopCnt), 64'd0);
   endtask

   task automatic wait_rsp(input string tag, input int exp_beats, input logic [63:0] exp_cnt);
      int n;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (RspValid) break;
      end
      check({tag, "_beats"}, 64'(n), 64'(exp_beats));
      check({tag, "_cnt"}, 64'(RspPopCnt), exp_cnt);
      check({tag, "_busy"}, 64'(Busy), 64'd1);
   endtask

   task automatic consume(input string tag);
      RspReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      RspReady = 1'b0;
      check({tag, "_rsp_drop"}, 64'(RspValid), 64'd0);
      check({tag, "_idle"}, 64'(Busy), 64'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      ReqValid   = 1'b0;
      ReqW       = 1'b0;
      ReqOperand = '0;
      Flush      = 1'b0;
      RspReady   = 1'b0;

      // reset state
      #3;
      check("rst_rsp_valid", 64'(RspValid), 64'd0);
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_cnt", 64'(RspPopCnt), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_req_ready", 64'(ReqReady), 64'd1);
      @(negedge clk);

      start_op("ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      wait_rsp("ones", 4, 64'd64);
      consume("ones");

      start_op("ones_w", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      wait_rsp("ones_w", 2, 64'd32);
      consume("ones_w");

      start_op("ends_w", 64'h8000_0000_0000_0001, 1'b1);
      wait_rsp("ends_w", 1, 64'd1);
      consume("ends_w");

      start_op("zero", 64'h0, 1'b0);
      wait_rsp("zero", 1, 64'd0);
      consume("zero");

      start_op("msb", 64'h8000_0000_0000_0000, 1'b0);
      wait_rsp("msb", 4, 64'd1);
      consume("msb");

      start_op("early", 64'h0000_0000_00F0_0101, 1'b0);
      wait_rsp("early", 2, 64'd6);
      consume("early");

      // backpressure, then back-to-back accept from DONE
      start_op("bp", 64'hFF, 1'b0);
      wait_rsp("bp", 1, 64'd8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(RspValid), 64'd1);
         check("bp_hold_cnt", 64'(RspPopCnt), 64'd8);
      end
      RspReady   = 1'b1;
      ReqValid   = 1'b1;
      ReqOperand = 64'h3;
      ReqW       = 1'b0;
      #1;
      check("b2b_req_ready", 64'(ReqReady), 64'd1);
      @(posedge clk);
      @(negedge clk);
      RspReady = 1'b0;
      ReqValid = 1'b0;
      check("b2b_rsp_drop", 64'(RspValid), 64'd0);
      check("b2b_busy", 64'(Busy), 64'd1);
      check("b2b_acc_clear", 64'(RspPopCnt), 64'd0);
      wait_rsp("b2b", 1, 64'd2);
      consume("b2b");

      // flush during COUNT beat 2 with a request waiting
      start_op("fl", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("fl_in_count", 64'(Busy), 64'd1);
      Flush      = 1'b1;
      ReqValid   = 1'b1;
      ReqOperand = 64'hF;
      #1;
      check("fl_req_ready", 64'(ReqReady), 64'd0);
      @(posedge clk);
      @(negedge clk);
      Flush = 1'b0;
      check("fl_no_rsp", 64'(RspValid), 64'd0);
      check("fl_idle", 64'(Busy), 64'd0);
      check("fl_acc_clear", 64'(RspPopCnt), 64'd0);
      start_op("fl_next", 64'hF, 1'b0);
      wait_rsp("fl_next", 1, 64'd4);
      consume("fl_next");

      // asynchronous reset mid-COUNT
      start_op("ar", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_rsp_valid", 64'(RspValid), 64'd0);
      check("ar_busy", 64'(Busy), 64'd0);
      check("ar_cnt", 64'(RspPopCnt), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("ar_req_ready", 64'(ReqReady), 64'd1);
      @(negedge clk);
      start_op("ar_next", 64'h0123_4567_89AB_CDEF, 1'b0);
      wait_rsp("ar_next", 4, 64'd32);
      consume("ar_next");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
